// File: rtl/lc4_pkg.sv
// Shared definitions for the LC4 decode queue: uop layout, field offsets and opcodes.
// The packed struct order matches the flat uop bus (first member is the MSB).
package lc4_pkg;

    localparam int UOP_W = 19;

    localparam int UOP_R1SEL_LSB = 16;
    localparam int UOP_R1RE_BIT  = 15;
    localparam int UOP_R2SEL_LSB = 12;
    localparam int UOP_R2RE_BIT  = 11;
    localparam int UOP_WSEL_LSB  = 8;
    localparam int UOP_WE_BIT    = 7;
    localparam int UOP_NZPWE_BIT = 6;
    localparam int UOP_PC1_BIT   = 5;
    localparam int UOP_LOAD_BIT  = 4;
    localparam int UOP_STORE_BIT = 3;
    localparam int UOP_BR_BIT    = 2;
    localparam int UOP_CTRL_BIT  = 1;
    localparam int UOP_ILL_BIT   = 0;

    localparam logic [3:0] OP_BR      = 4'b0000;
    localparam logic [3:0] OP_ARITH   = 4'b0001;
    localparam logic [3:0] OP_CMP     = 4'b0010;
    localparam logic [3:0] OP_JSR     = 4'b0100;
    localparam logic [3:0] OP_LOGIC   = 4'b0101;
    localparam logic [3:0] OP_LDR     = 4'b0110;
    localparam logic [3:0] OP_STR     = 4'b0111;
    localparam logic [3:0] OP_RTI     = 4'b1000;
    localparam logic [3:0] OP_CONST   = 4'b1001;
    localparam logic [3:0] OP_SHIFT   = 4'b1010;
    localparam logic [3:0] OP_JMP     = 4'b1100;
    localparam logic [3:0] OP_HICONST = 4'b1101;
    localparam logic [3:0] OP_TRAP    = 4'b1111;

    localparam logic [2:0] ARITH_MUL = 3'b001;
    localparam logic [2:0] ARITH_DIV = 3'b011;
    localparam logic [1:0] SHIFT_MOD = 2'b11;

    typedef struct packed {
        logic [2:0] r1sel;
        logic       r1re;
        logic [2:0] r2sel;
        logic       r2re;
        logic [2:0] wsel;
        logic       regfile_we;
        logic       nzp_we;
        logic       sel_pc1;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_control;
        logic       illegal;
    } uop_t;

endpackage

// File: rtl/lc4_uop_decode.sv
// Combinational LC4 instruction decoder producing one uop per raw instruction.
// Illegal encodings keep their register selects but lose every write/read enable.
module lc4_uop_decode
    import lc4_pkg::*;
#(
    parameter bit SUPPORT_MULDIV = 1'b1
) (
    input  logic [15:0] insn,
    output uop_t        uop
);

    logic [3:0] opcode;
    logic       muldiv_op;
    logic       bad_opcode;
    uop_t       raw;

    assign opcode = insn[15:12];

    always_comb begin
        raw        = '0;
        raw.r1sel  = insn[8:6];
        raw.r2sel  = insn[2:0];
        raw.wsel   = insn[11:9];
        muldiv_op  = 1'b0;
        bad_opcode = 1'b0;

        case (opcode)
            OP_BR: raw.is_branch = (insn != 16'h0000);
            OP_ARITH: begin
                raw.r1re       = 1'b1;
                raw.r2re       = ~insn[5];
                raw.regfile_we = 1'b1;
                muldiv_op      = (insn[5:3] == ARITH_MUL) || (insn[5:3] == ARITH_DIV);
            end
            OP_CMP: begin
                raw.r1sel = insn[11:9];
                raw.r1re  = 1'b1;
                raw.r2re  = ~insn[8];
            end
            OP_JSR: begin
                // insn[11] separates JSR (immediate) from JSRR (register target)
                raw.r1re       = ~insn[11];
                raw.wsel       = 3'd7;
                raw.regfile_we = 1'b1;
                raw.sel_pc1    = 1'b1;
                raw.is_control = 1'b1;
            end
            OP_LOGIC: begin
                raw.r1re       = 1'b1;
                raw.r2re       = ~insn[5] & (insn[4:3] != 2'b01);
                raw.regfile_we = 1'b1;
            end
            OP_LDR: begin
                raw.r1re       = 1'b1;
                raw.regfile_we = 1'b1;
                raw.is_load    = 1'b1;
            end
            OP_STR: begin
                raw.r1re     = 1'b1;
                raw.r2sel    = insn[11:9];
                raw.r2re     = 1'b1;
                raw.is_store = 1'b1;
            end
            OP_RTI: begin
                raw.r1sel      = 3'd7;
                raw.r1re       = 1'b1;
                raw.is_control = 1'b1;
            end
            OP_CONST: raw.regfile_we = 1'b1;
            OP_SHIFT: begin
                raw.r1re       = 1'b1;
                raw.regfile_we = 1'b1;
                raw.r2re       = (insn[5:4] == SHIFT_MOD);
                muldiv_op      = (insn[5:4] == SHIFT_MOD);
            end
            OP_JMP: begin
                raw.r1re       = ~insn[11];
                raw.is_control = 1'b1;
            end
            OP_HICONST: begin
                raw.r1sel      = insn[11:9];
                raw.r1re       = 1'b1;
                raw.regfile_we = 1'b1;
            end
            OP_TRAP: begin
                raw.wsel       = 3'd7;
                raw.regfile_we = 1'b1;
                raw.sel_pc1    = 1'b1;
                raw.is_control = 1'b1;
            end
            default: bad_opcode = 1'b1;
        endcase

        raw.nzp_we  = raw.regfile_we | (opcode == OP_CMP);
        raw.illegal = bad_opcode | (muldiv_op & ~SUPPORT_MULDIV);

        uop = raw;
        if (raw.illegal) begin
            uop.regfile_we = 1'b0;
            uop.nzp_we     = 1'b0;
            uop.r1re       = 1'b0;
            uop.r2re       = 1'b0;
        end
    end

endmodule

// File: rtl/lc4_decode_queue.sv
// Decode buffer between fetch and rename: decodes at enqueue, tags each entry with a
// wrapping sequence number and holds DEPTH uops in a valid/ready FIFO with flush.
module lc4_decode_queue
    import lc4_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter bit SUPPORT_MULDIV = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_insn,
    input  logic [15:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_insn,
    output logic [15:0]                out_pc,
    output logic [TAG_W-1:0]           out_tag,
    output logic [UOP_W-1:0]           out_uop,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [15:0]      insn_mem [DEPTH];
    logic [15:0]      pc_mem   [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    uop_t             uop_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [TAG_W-1:0] tag_ctr;
    uop_t             dec_uop;
    logic             enq;
    logic             deq;

    lc4_uop_decode #(
        .SUPPORT_MULDIV(SUPPORT_MULDIV)
    ) u_decode (
        .insn(in_insn),
        .uop (dec_uop)
    );

    // Flush blocks enqueue directly so a redirected insn never slips in
    assign in_ready  = (count < CNT_W'(DEPTH)) & ~flush;
    assign out_valid = (count != '0);
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            tag_ctr <= '0;
        end else begin
            if (enq) tag_ctr <= tag_ctr + TAG_W'(1);
            // The tag counter survives a flush so sequence numbers stay unique
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
                if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
                if (enq && !deq)      count <= count + CNT_W'(1);
                else if (!enq && deq) count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            insn_mem[wr_ptr] <= in_insn;
            pc_mem[wr_ptr]   <= in_pc;
            tag_mem[wr_ptr]  <= tag_ctr;
            uop_mem[wr_ptr]  <= dec_uop;
        end
    end

    assign out_insn = insn_mem[rd_ptr];
    assign out_pc   = pc_mem[rd_ptr];
    assign out_tag  = tag_mem[rd_ptr];
    assign out_uop  = uop_mem[rd_ptr];

endmodule

// File: tb/tb_lc4_decode_queue.sv
// Bench for lc4_decode_queue: directed scenarios plus random traffic against a queue model.
// A second instance built without MUL/DIV/MOD shares all inputs.
module tb_lc4_decode_queue;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [15:0] in_insn, in_pc;
    logic        in_ready, out_valid, b_in_ready, b_out_valid;
    logic [15:0] out_insn, out_pc, b_out_insn, b_out_pc;
    logic [3:0]  out_tag, b_out_tag;
    logic [18:0] out_uop, b_out_uop;
    logic [2:0]  count, b_count;

    always #5 clk = ~clk;

    lc4_decode_queue #(.DEPTH(4), .TAG_W(4), .SUPPORT_MULDIV(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_insn(in_insn), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_insn(out_insn), .out_pc(out_pc), .out_tag(out_tag), .out_uop(out_uop), .count(count));

    lc4_decode_queue #(.DEPTH(4), .TAG_W(4), .SUPPORT_MULDIV(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_insn(in_insn), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_insn(b_out_insn), .out_pc(b_out_pc), .out_tag(b_out_tag), .out_uop(b_out_uop),
        .count(b_count));

    typedef struct {
        logic [15:0] insn;
        logic [15:0] pc;
        logic [3:0]  tag;
    } ent_t;

    ent_t mq[$];
    int   mtag = 0;
    int   ntot = 0;
    int   npass = 0;

    // Reference decode straight from the instruction-class rules
    function automatic logic [18:0] ref_uop(input logic [15:0] i, input bit md);
        logic [3:0] op;
        logic [2:0] r1sel, r2sel, wsel;
        bit arith, cmp, jsr, jsrr, lgc, ldr, str, rti, cnst, shf, jmpr, jmp, hic, trap;
        bit mul, dv, mdo, ill, r1re, r2re, we, nzp, pc1, br, ctrl;
        op    = i[15:12];
        arith = (op == 4'd1);  cmp = (op == 4'd2);
        jsr   = (op == 4'd4) && i[11];  jsrr = (op == 4'd4) && !i[11];
        lgc   = (op == 4'd5);  ldr = (op == 4'd6);  str = (op == 4'd7);
        rti   = (op == 4'd8);  cnst = (op == 4'd9); shf = (op == 4'd10);
        jmpr  = (op == 4'd12) && !i[11];  jmp = (op == 4'd12) && i[11];
        hic   = (op == 4'd13); trap = (op == 4'd15);
        mul   = arith && (i[5:3] == 3'd1);
        dv    = arith && (i[5:3] == 3'd3);
        mdo   = shf && (i[5:4] == 2'd3);
        ill   = (op == 4'd3) || (op == 4'd11) || (op == 4'd14) || (!md && (mul || dv || mdo));
        r1sel = (cmp || hic) ? i[11:9] : (rti ? 3'd7 : i[8:6]);
        r2sel = str ? i[11:9] : i[2:0];
        wsel  = (jsr || jsrr || trap) ? 3'd7 : i[11:9];
        r1re  = arith || cmp || jsrr || lgc || ldr || str || rti || shf || jmpr || hic;
        r2re  = (arith && !i[5]) || (cmp && !i[8]) || str || mdo ||
                (lgc && (i[5:3] == 3'd0 || i[5:3] == 3'd2 || i[5:3] == 3'd3));
        we    = arith || jsr || jsrr || lgc || ldr || cnst || shf || hic || trap;
        nzp   = we || cmp;
        pc1   = trap || jsr || jsrr;
        br    = (op == 4'd0) && (i != 16'h0000);
        ctrl  = jsr || jsrr || rti || jmpr || jmp || trap;
        if (ill) begin
            r1re = 0; r2re = 0; we = 0; nzp = 0;
        end
        return {r1sel, r1re, r2sel, r2re, wsel, we, nzp, pc1, ldr, str, br, ctrl, ill};
    endfunction

    // Advance one clock, updating the model with this cycle's handshakes
    task automatic tick();
        bit e, d;
        e = in_valid && (mq.size() < 4) && !flush;
        d = (mq.size() > 0) && out_ready;
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (d) void'(mq.pop_front());
            if (e) begin
                mq.push_back('{in_insn, in_pc, 4'(mtag)});
                mtag = (mtag + 1) % 16;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 0; out_ready = 0; flush = 0;
        rst_n = 0;
        mq.delete();
        mtag = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        in_valid = 0; out_ready = 0; flush = 0; in_insn = 0; in_pc = 0;
        rst_n = 1;
        #2 rst_n = 0;
        @(negedge clk); #1;
        ntot++;
        if ({count, out_valid, b_count, b_out_valid} !== 8'h00)
            $display("FAIL reset_state: got %h want 00", {count, out_valid, b_count, b_out_valid});
        else npass++;
        @(negedge clk);
        rst_n = 1;
        #1;
        ntot++;
        if ({in_ready, out_valid, count} !== 5'b10000)
            $display("FAIL reset_release: got %b want 10000", {in_ready, out_valid, count});
        else npass++;
    endtask

    task automatic test_single_add();
        in_valid = 1; in_insn = 16'h1242; in_pc = 16'h0100; out_ready = 0;
        #1;
        ntot++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL add_no_bypass: got %b want 10", {in_ready, out_valid});
        else npass++;
        tick();
        in_valid = 0;
        #1;
        ntot++;
        if ({out_valid, count, out_tag} !== {1'b1, 3'd1, 4'd0})
            $display("FAIL add_head_state: got %h want %h", {out_valid, count, out_tag}, {1'b1, 3'd1, 4'd0});
        else npass++;
        ntot++;
        if ({out_uop[18:16], out_uop[14:12], out_uop[10:8], out_uop[7], out_uop[11]} !== 11'b001_010_001_1_1)
            $display("FAIL add_fields: got %b want 00101000111",
                     {out_uop[18:16], out_uop[14:12], out_uop[10:8], out_uop[7], out_uop[11]});
        else npass++;
        ntot++;
        if ({out_insn, out_pc, out_uop} !== {16'h1242, 16'h0100, ref_uop(16'h1242, 1)})
            $display("FAIL add_entry: got %h want %h", {out_insn, out_pc, out_uop},
                     {16'h1242, 16'h0100, ref_uop(16'h1242, 1)});
        else npass++;
        out_ready = 1;
        tick();
    endtask

    task automatic test_fill_drain();
        logic [15:0] sent[4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_insn = 16'($urandom); in_pc = 16'(i * 2); sent[i] = in_insn;
            tick();
        end
        in_insn = 16'hFFFF;
        #1;
        ntot++;
        if ({in_ready, count} !== {1'b0, 3'd4})
            $display("FAIL full_state: got %h want %h", {in_ready, count}, {1'b0, 3'd4});
        else npass++;
        tick();
        in_valid = 0;
        #1;
        ntot++;
        if ({count, out_insn} !== {3'd4, sent[0]})
            $display("FAIL full_ignore: got %h want %h", {count, out_insn}, {3'd4, sent[0]});
        else npass++;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            ntot++;
            if ({out_valid, out_insn, out_tag, out_uop} !== {1'b1, sent[i], 4'(i), ref_uop(sent[i], 1)})
                $display("FAIL drain_order: got %h want %h", {out_valid, out_insn, out_tag, out_uop},
                         {1'b1, sent[i], 4'(i), ref_uop(sent[i], 1)});
            else npass++;
            tick();
            #1;
        end
        ntot++;
        if ({out_valid, count} !== 4'b0000)
            $display("FAIL drain_empty: got %b want 0000", {out_valid, count});
        else npass++;
    endtask

    task automatic test_stream_wrap();
        do_reset();
        in_valid = 1; out_ready = 1;
        for (int k = 0; k < 20; k++) begin
            in_insn = 16'($urandom); in_pc = 16'(k);
            #1;
            if (k > 0) begin
                ntot++;
                if ({count, out_valid, out_tag, out_insn} !== {3'd1, 1'b1, 4'((k - 1) % 16), mq[0].insn})
                    $display("FAIL stream_wrap: got %h want %h", {count, out_valid, out_tag, out_insn},
                             {3'd1, 1'b1, 4'((k - 1) % 16), mq[0].insn});
                else npass++;
            end
            tick();
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_flush();
        int tag_before;
        in_valid = 1; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_insn = 16'h9000 + 16'(i); in_pc = 16'(i);
            tick();
        end
        tag_before = mtag;
        in_insn = 16'h5555; out_ready = 1; flush = 1;
        #1;
        ntot++;
        if ({count, in_ready} !== {3'd3, 1'b0})
            $display("FAIL flush_block: got %h want %h", {count, in_ready}, {3'd3, 1'b0});
        else npass++;
        tick();
        flush = 0; in_valid = 0;
        #1;
        ntot++;
        if ({count, out_valid} !== 4'b0000)
            $display("FAIL flush_clear: got %b want 0000", {count, out_valid});
        else npass++;
        in_valid = 1; in_insn = 16'h1242; out_ready = 0;
        tick();
        in_valid = 0;
        #1;
        ntot++;
        if ({out_valid, out_tag} !== {1'b1, 4'(tag_before)})
            $display("FAIL flush_tag: got %h want %h", {out_valid, out_tag}, {1'b1, 4'(tag_before)});
        else npass++;
        out_ready = 1;
        tick();
    endtask

    task automatic test_decode_misc();
        logic [15:0] v[4];
        v[0] = 16'h3000; v[1] = 16'h4000; v[2] = 16'h8000; v[3] = 16'h0000;
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_insn = v[i]; in_pc = 16'h2000 + 16'(i);
            tick();
        end
        in_valid = 0; out_ready = 1;
        #1;
        ntot++;
        if ({out_uop[0], out_uop[7]} !== 2'b10)
            $display("FAIL dec_3000: got %b want 10", {out_uop[0], out_uop[7]});
        else npass++;
        tick(); #1;
        ntot++;
        if ({out_uop[10:8], out_uop[1]} !== 4'b1111)
            $display("FAIL dec_4000: got %b want 1111", {out_uop[10:8], out_uop[1]});
        else npass++;
        tick(); #1;
        ntot++;
        if (out_uop[18:16] !== 3'd7)
            $display("FAIL dec_8000: got %h want 7", out_uop[18:16]);
        else npass++;
        tick(); #1;
        ntot++;
        if ({out_uop[2], out_uop} !== {1'b0, ref_uop(16'h0000, 1)})
            $display("FAIL dec_0000: got %h want %h", {out_uop[2], out_uop}, {1'b0, ref_uop(16'h0000, 1)});
        else npass++;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic er;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 19) == 0);
            in_insn   = 16'($urandom);
            in_pc     = 16'($urandom);
            #1;
            er = (mq.size() < 4) && !flush;
            ntot++;
            if ({in_ready, out_valid, count, b_count} !== {er, mq.size() != 0, 3'(mq.size()), 3'(mq.size())})
                $display("FAIL rand_ctrl: got %h want %h", {in_ready, out_valid, count, b_count},
                         {er, mq.size() != 0, 3'(mq.size()), 3'(mq.size())});
            else npass++;
            if (mq.size() > 0) begin
                ntot++;
                if ({out_insn, out_pc, out_tag, out_uop} !== {mq[0].insn, mq[0].pc, mq[0].tag, ref_uop(mq[0].insn, 1)})
                    $display("FAIL rand_head: got %h want %h", {out_insn, out_pc, out_tag, out_uop},
                             {mq[0].insn, mq[0].pc, mq[0].tag, ref_uop(mq[0].insn, 1)});
                else npass++;
                ntot++;
                if ({b_out_insn, b_out_uop} !== {mq[0].insn, ref_uop(mq[0].insn, 0)})
                    $display("FAIL rand_nomuldiv: got %h want %h", {b_out_insn, b_out_uop},
                             {mq[0].insn, ref_uop(mq[0].insn, 0)});
                else npass++;
            end
            tick();
        end
        flush = 0;
    endtask

    task automatic test_muldiv_async_reset();
        do_reset();
        in_valid = 1; in_insn = 16'h1248; in_pc = 16'h0040; out_ready = 0;
        tick();
        in_insn = 16'h1242;
        tick();
        in_valid = 0;
        #1;
        ntot++;
        if ({b_out_uop, out_uop[0]} !== {ref_uop(16'h1248, 0), 1'b0} || b_out_uop[0] !== 1'b1)
            $display("FAIL mul_illegal: got %h want %h", {b_out_uop, out_uop[0]}, {ref_uop(16'h1248, 0), 1'b0});
        else npass++;
        ntot++;
        if ({count, b_count} !== {3'd2, 3'd2})
            $display("FAIL pre_reset_count: got %h want %h", {count, b_count}, {3'd2, 3'd2});
        else npass++;
        #2 rst_n = 0;
        #1;
        ntot++;
        if ({count, out_valid, b_count, b_out_valid} !== 8'h00)
            $display("FAIL async_reset: got %h want 00", {count, out_valid, b_count, b_out_valid});
        else npass++;
        mq.delete();
        mtag = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_add();
        test_fill_drain();
        test_stream_wrap();
        test_flush();
        test_decode_misc();
        test_random();
        test_muldiv_async_reset();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
